alu_op_sequencer: RTL and testbench

Command sequencer for the 8-bit gate-level ALU (`Alu8bit`). It sits directly upstream of the ALU and consumes its result.
- Accepts one operation at a time over a valid/ready command port.
- Drives the ALU operand, carry and select inputs from registers and waits a fixed settle interval for the gate-level carry chain.
- Captures `s`/`cout` and returns them with a zero flag over a valid/ready response port.
- Supports carry chaining, so multi-byte arithmetic can be issued as a sequence of byte commands.

---
 rtl/alu_op_sequencer_pkg.sv | 15 +
 rtl/alu_op_sequencer_if.sv | 46 ++++
 rtl/alu_op_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Build option: ALU_SEQ_ACC_EN adds accumulator-sourced operand a.
package alu_seq_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_SEL_W  = 4;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command/response handshake bundle between a host and the ALU sequencer.
// Build option: ALU_SEQ_ACC_EN adds the cmd_use_acc signal.
interface alu_op_sequencer_if #(
    parameter int DATA_W = alu_seq_pkg::DEF_DATA_W,
    parameter int SEL_W  = alu_seq_pkg::DEF_SEL_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic              cmd_cin;
    logic              cmd_chain;
    logic [SEL_W-1:0]  cmd_sel;
`ifdef ALU_SEQ_ACC_EN
    logic              cmd_use_acc;
`endif

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_s;
    logic              rsp_cout;
    logic              rsp_zero;

    // Host side: issues commands, consumes responses.
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_chain, cmd_sel,
`ifdef ALU_SEQ_ACC_EN
        output cmd_use_acc,
`endif
        input  cmd_ready,
        input  rsp_valid, rsp_s, rsp_cout, rsp_zero,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_chain, cmd_sel,
`ifdef ALU_SEQ_ACC_EN
        input  cmd_use_acc,
`endif
        output cmd_ready,
        output rsp_valid, rsp_s, rsp_cout, rsp_zero,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one operation at a time into a gate-level ALU, waits for the carry
// chain to settle, then returns the result. Build option: ALU_SEQ_ACC_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SEL_W      = DEF_SEL_W,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_s,
    input  logic              alu_cout
);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic [CNT_W-1:0]  r_settle_cnt;
    logic              r_carry;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic              r_alu_cin;
    logic [SEL_W-1:0]  r_alu_sel;
    logic [DATA_W-1:0] r_rsp_s;
    logic              r_rsp_cout;
    logic              r_rsp_zero;

    logic              w_accept;
    logic              w_capture;
    logic              w_rsp_done;
    logic [DATA_W-1:0] w_a_src;

    assign w_accept   = bus.cmd_valid && (r_state == IDLE);
    assign w_capture  = (r_state == SETTLE) && (r_settle_cnt == '0);
    assign w_rsp_done = bus.rsp_ready && (r_state == RESP);

`ifdef ALU_SEQ_ACC_EN
    assign w_a_src = bus.cmd_use_acc ? r_rsp_s : bus.cmd_a;
`else
    assign w_a_src = bus.cmd_a;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default assignment first, so no path through the case leaves
    // w_next_state unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_next_state = SETTLE;
            SETTLE:  if (w_capture)  w_next_state = RESP;
            RESP:    if (w_rsp_done) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Ready and valid are pure state decodes: no combinational path from
    // cmd_valid or rsp_ready.
    always_comb begin
        bus.cmd_ready = (r_state == IDLE);
        bus.rsp_valid = (r_state == RESP);
    end

    // NOTE: every datapath register is asynchronously reset so an aborted
    // operation leaves nothing behind on the ALU or response ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_cin    <= 1'b0;
            r_alu_sel    <= '0;
            r_settle_cnt <= '0;
        end else if (w_accept) begin
            r_alu_a      <= w_a_src;
            r_alu_b      <= bus.cmd_b;
            r_alu_cin    <= bus.cmd_chain ? r_carry : bus.cmd_cin;
            r_alu_sel    <= bus.cmd_sel;
            r_settle_cnt <= CNT_W'(SETTLE_CYC - 1);
        end else if ((r_state == SETTLE) && (r_settle_cnt != '0)) begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
        end
    end

    // Capture registers keep their values after the handshake; only the
    // next capture overwrites them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_s    <= '0;
            r_rsp_cout <= 1'b0;
            r_rsp_zero <= 1'b0;
            r_carry    <= 1'b0;
        end else if (w_capture) begin
            r_rsp_s    <= alu_s;
            r_rsp_cout <= alu_cout;
            r_rsp_zero <= (alu_s == '0);
            r_carry    <= alu_cout;
        end
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_cin      = r_alu_cin;
    assign alu_sel      = r_alu_sel;
    assign bus.rsp_s    = r_rsp_s;
    assign bus.rsp_cout = r_rsp_cout;
    assign bus.rsp_zero = r_rsp_zero;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an adder stub in place of the ALU.
// Build option: ALU_SEQ_ACC_EN enables the accumulator-operand steps.
module tb_alu_op_sequencer;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_cin;
    logic [SEL_W-1:0]  alu_sel;
    logic [DATA_W-1:0] alu_s;
    logic              alu_cout;

    int n_pass;
    int n_total;

    alu_op_sequencer_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

    alu_op_sequencer #(
        .DATA_W     (DATA_W),
        .SEL_W      (SEL_W),
        .SETTLE_CYC (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_sel  (alu_sel),
        .alu_s    (alu_s),
        .alu_cout (alu_cout)
    );

    // Adder stub: same result for every select value.
    assign {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic chain, input logic [3:0] sel, input logic use_acc);
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_cin   = cin;
        bus.cmd_chain = chain;
        bus.cmd_sel   = sel;
`ifdef ALU_SEQ_ACC_EN
        bus.cmd_use_acc = use_acc;
`else
        if (use_acc) $display("note: use_acc ignored in this build");
`endif
        bus.cmd_valid = 1'b1;
        check("ready_before_accept", 32'(bus.cmd_ready), 32'd1);
        step(1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        step(1);
        bus.rsp_ready = 1'b0;
        check("valid_after_handshake", 32'(bus.rsp_valid), 32'd0);
        check("ready_after_handshake", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_cin   = 1'b0;
        bus.cmd_chain = 1'b0;
        bus.cmd_sel   = '0;
`ifdef ALU_SEQ_ACC_EN
        bus.cmd_use_acc = 1'b0;
`endif
        bus.rsp_ready = 1'b0;

        #2;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_alu_a",     32'(alu_a),         32'd0);
        check("rst_alu_b",     32'(alu_b),         32'd0);
        check("rst_alu_cin",   32'(alu_cin),       32'd0);
        check("rst_alu_sel",   32'(alu_sel),       32'd0);
        check("rst_rsp_s",     32'(bus.rsp_s),     32'd0);
        check("rst_rsp_zero",  32'(bus.rsp_zero),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // 0x73 + 0xAF = 0x122
        issue(8'h73, 8'hAF, 1'b0, 1'b0, 4'b0000, 1'b0);
        check("c1_busy",      32'(bus.cmd_ready), 32'd0);
        check("c1_alu_a",     32'(alu_a),         32'h73);
        check("c1_alu_b",     32'(alu_b),         32'hAF);
        check("c1_alu_cin",   32'(alu_cin),       32'd0);
        step(1);
        check("c1_not_yet",   32'(bus.rsp_valid), 32'd0);
        step(1);
        check("c1_valid",     32'(bus.rsp_valid), 32'd1);
        check("c1_s",         32'(bus.rsp_s),     32'h22);
        check("c1_cout",      32'(bus.rsp_cout),  32'd1);
        check("c1_zero",      32'(bus.rsp_zero),  32'd0);
        handshake();
        check("c1_s_kept",    32'(bus.rsp_s),     32'h22);

        // Chained: stored carry 1 replaces cmd_cin 0
        issue(8'h01, 8'h00, 1'b0, 1'b1, 4'b0001, 1'b0);
        check("c2_alu_cin",   32'(alu_cin),       32'd1);
        check("c2_alu_sel",   32'(alu_sel),       32'd1);
        step(2);
        check("c2_s",         32'(bus.rsp_s),     32'h02);
        check("c2_cout",      32'(bus.rsp_cout),  32'd0);
        handshake();

        // Wrap to zero
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 4'b0010, 1'b0);
        step(2);
        check("c3_s",         32'(bus.rsp_s),     32'h00);
        check("c3_cout",      32'(bus.rsp_cout),  32'd1);
        check("c3_zero",      32'(bus.rsp_zero),  32'd1);
        handshake();

        // Backpressure with a second command waiting
        issue(8'h10, 8'h20, 1'b0, 1'b0, 4'b0011, 1'b0);
        step(2);
        check("bp_first_s",   32'(bus.rsp_s),     32'h30);
        bus.cmd_a     = 8'h80;
        bus.cmd_b     = 8'h80;
        bus.cmd_cin   = 1'b0;
        bus.cmd_chain = 1'b0;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("bp_ready_low", 32'(bus.cmd_ready), 32'd0);
            check("bp_valid",     32'(bus.rsp_valid), 32'd1);
            check("bp_s_stable",  32'(bus.rsp_s),     32'h30);
            check("bp_no_accept", 32'(alu_a),         32'h10);
        end
        bus.rsp_ready = 1'b1;
        step(1);
        bus.rsp_ready = 1'b0;
        check("bp_hs_idle",   32'(bus.cmd_ready), 32'd1);
        check("bp_hs_valid",  32'(bus.rsp_valid), 32'd0);
        step(1);
        bus.cmd_valid = 1'b0;
        check("bp_accept2",   32'(bus.cmd_ready), 32'd0);
        check("bp_alu_a2",    32'(alu_a),         32'h80);
        step(2);
        check("bp_s2",        32'(bus.rsp_s),     32'h00);
        check("bp_cout2",     32'(bus.rsp_cout),  32'd1);
        check("bp_zero2",     32'(bus.rsp_zero),  32'd1);
        handshake();

        // Reset one cycle into SETTLE
        issue(8'h73, 8'hAF, 1'b1, 1'b0, 4'b0101, 1'b0);
        step(1);
        rst_n = 1'b0;
        #1;
        check("mr_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mr_alu_a",     32'(alu_a),         32'd0);
        check("mr_alu_cin",   32'(alu_cin),       32'd0);
        check("mr_alu_sel",   32'(alu_sel),       32'd0);
        check("mr_rsp_s",     32'(bus.rsp_s),     32'd0);
        check("mr_rsp_cout",  32'(bus.rsp_cout),  32'd0);
        check("mr_rsp_zero",  32'(bus.rsp_zero),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        check("mr_no_rsp",    32'(bus.rsp_valid), 32'd0);
        check("mr_ready",     32'(bus.cmd_ready), 32'd1);

        // Chain after reset: stored carry was cleared
        issue(8'h01, 8'h02, 1'b1, 1'b1, 4'b0000, 1'b0);
        check("pr_alu_cin",   32'(alu_cin),       32'd0);
        step(2);
        check("pr_s",         32'(bus.rsp_s),     32'h03);
        check("pr_cout",      32'(bus.rsp_cout),  32'd0);
        handshake();

`ifdef ALU_SEQ_ACC_EN
        issue(8'h73, 8'hAF, 1'b0, 1'b0, 4'b0000, 1'b0);
        step(2);
        check("acc_base_s",   32'(bus.rsp_s),     32'h22);
        handshake();
        issue(8'h99, 8'h10, 1'b0, 1'b0, 4'b0000, 1'b1);
        check("acc_alu_a",    32'(alu_a),         32'h22);
        step(2);
        check("acc_s",        32'(bus.rsp_s),     32'h32);
        check("acc_cout",     32'(bus.rsp_cout),  32'd0);
        handshake();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
